ras_ckpt: RTL and testbench

Parametrised return-address stack with speculative checkpoint/restore, for the frontend branch predictor of the application core. It generalises the fixed-depth RAS:
- depth and address width are parameters;
- overflow wraps circularly, discarding the oldest entry;
- a simultaneous pop+push replaces the top entry;
- a one-level checkpoint of the stack pointer and count can be saved and restored on misprediction.

---
 rtl/ras_ckpt.sv | 113 +++++++++++
 tb/tb_ras_ckpt.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// Return-address stack with circular overflow, pop+push replace, and a
// one-level speculative checkpoint of the stack pointer and occupancy.
module ras_ckpt #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] push_addr_i,
    input  logic            ckpt_save_i,
    input  logic            ckpt_restore_i,
    output logic            top_valid_o,
    output logic [VLEN-1:0] top_addr_o,
    output logic [CW-1:0]   count_o,
    output logic            overflow_o,
    output logic            underflow_o
);

    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TW-1:0] TP_LAST = TW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DEPTH-1:0][VLEN-1:0] mem;
    logic [TW-1:0]              tp, tp_nx, tp_inc, tp_dec;
    logic [CW-1:0]              cnt, cnt_nx;
    logic [TW-1:0]              ckpt_tp;
    logic [CW-1:0]              ckpt_cnt;
    logic                       ckpt_vld;
    logic                       wr_en;
    logic [TW-1:0]              wr_idx;
    logic                       ovf_nx, unf_nx;

    // Explicit modulo-DEPTH wrap so non-power-of-two depths behave.
    assign tp_inc = (tp == TP_LAST) ? '0 : tp + TW'(1);
    assign tp_dec = (tp == '0) ? TP_LAST : tp - TW'(1);

    always_comb begin
        tp_nx  = tp;
        cnt_nx = cnt;
        wr_en  = 1'b0;
        wr_idx = tp;
        ovf_nx = 1'b0;
        unf_nx = 1'b0;
        if (ckpt_restore_i) begin
            if (ckpt_vld) begin
                tp_nx  = ckpt_tp;
                cnt_nx = ckpt_cnt;
            end else begin
                cnt_nx = '0;
            end
        end else if (push_i && (!pop_i || cnt == '0)) begin
            tp_nx  = tp_inc;
            wr_en  = 1'b1;
            wr_idx = tp_inc;
            if (cnt == CNT_FULL) ovf_nx = 1'b1;
            else                 cnt_nx = cnt + CW'(1);
        end else if (push_i && pop_i) begin
            // Return immediately followed by a call: replace the top in place.
            wr_en  = 1'b1;
            wr_idx = tp;
        end else if (pop_i) begin
            if (cnt != '0) begin
                tp_nx  = tp_dec;
                cnt_nx = cnt - CW'(1);
            end else begin
                unf_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp          <= '0;
            cnt         <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            tp          <= tp_nx;
            cnt         <= cnt_nx;
            overflow_o  <= ovf_nx;
            underflow_o <= unf_nx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= push_addr_i;
        end
    end

    // Save captures post-update state, so a coincident restore is what sticks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ckpt_tp  <= '0;
            ckpt_cnt <= '0;
            ckpt_vld <= 1'b0;
        end else if (ckpt_save_i) begin
            ckpt_tp  <= tp_nx;
            ckpt_cnt <= cnt_nx;
            ckpt_vld <= 1'b1;
        end
    end

    assign top_addr_o  = mem[tp];
    assign top_valid_o = (cnt != '0);
    assign count_o     = cnt;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: DEPTH=2 main instance plus a DEPTH=3 instance
// sharing the same command inputs for the non-power-of-two wrap scenario.
module tb_ras_ckpt;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0, pop = 1'b0, save = 1'b0, restore = 1'b0;
    logic [31:0] addr = '0;

    logic        v2, o2, u2, v3, o3, u3;
    logic [31:0] t2, t3;
    logic [1:0]  c2, c3;

    // Packed view: {valid, count, top, overflow, underflow}
    logic [36:0] st2, st3;
    assign st2 = {v2, c2, t2, o2, u2};
    assign st3 = {v3, c3, t3, o3, u3};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ras_ckpt #(.DEPTH(2), .VLEN(32)) u_d2 (
        .clk_i(clk), .rst_i(rst), .push_i(push), .pop_i(pop),
        .push_addr_i(addr), .ckpt_save_i(save), .ckpt_restore_i(restore),
        .top_valid_o(v2), .top_addr_o(t2), .count_o(c2),
        .overflow_o(o2), .underflow_o(u2)
    );

    ras_ckpt #(.DEPTH(3), .VLEN(32)) u_d3 (
        .clk_i(clk), .rst_i(rst), .push_i(push), .pop_i(pop),
        .push_addr_i(addr), .ckpt_save_i(save), .ckpt_restore_i(restore),
        .top_valid_o(v3), .top_addr_o(t3), .count_o(c3),
        .overflow_o(o3), .underflow_o(u3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic ps, input logic pp, input logic [31:0] a,
                       input logic sv, input logic rs);
        push = ps; pop = pp; addr = a; save = sv; restore = rs;
        step();
        push = 1'b0; pop = 1'b0; addr = '0; save = 1'b0; restore = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (st2 !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", st2, 37'h0);
        end
        step();
        rst = 1'b0;
        cmd(1, 0, 32'hAAA, 0, 0);
        cmd(1, 0, 32'hBBB, 0, 0);
        n_checks++;
        if (st2 !== {1'b1, 2'd2, 32'hBBB, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_prefill: got %h expected %h", st2, {1'b1, 2'd2, 32'hBBB, 1'b0, 1'b0});
        end
        // Mid-cycle assertion: outputs must clear before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (st2 !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", st2, 37'h0);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        cmd(1, 0, 32'h100, 0, 0);
        cmd(1, 0, 32'h200, 0, 0);
        n_checks++;
        if (st2 !== {1'b1, 2'd2, 32'h200, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL push_full: got %h expected %h", st2, {1'b1, 2'd2, 32'h200, 1'b0, 1'b0});
        end
        cmd(1, 0, 32'h300, 0, 0);
        n_checks++;
        if (st2 !== {1'b1, 2'd2, 32'h300, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL push_overflow: got %h expected %h", st2, {1'b1, 2'd2, 32'h300, 1'b1, 1'b0});
        end
        cmd(0, 0, 32'h0, 0, 0);
        n_checks++;
        if (o2 !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_one_cycle: got %b expected 0", o2);
        end
        cmd(0, 1, 32'h0, 0, 0);
        n_checks++;
        if (st2 !== {1'b1, 2'd1, 32'h200, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pop_first: got %h expected %h", st2, {1'b1, 2'd1, 32'h200, 1'b0, 1'b0});
        end
        cmd(0, 1, 32'h0, 0, 0);
        n_checks++;
        if ({v2, c2, o2, u2} !== 5'b0_00_0_0) begin
            n_fail++;
            $display("FAIL pop_empty: got %b expected %b", {v2, c2, o2, u2}, 5'b0_00_0_0);
        end
        cmd(0, 1, 32'h0, 0, 0);
        n_checks++;
        if ({v2, c2, o2, u2} !== 5'b0_00_0_1) begin
            n_fail++;
            $display("FAIL underflow: got %b expected %b", {v2, c2, o2, u2}, 5'b0_00_0_1);
        end
        cmd(0, 1, 32'h0, 0, 0);
        n_checks++;
        if ({c2, u2} !== 3'b00_1) begin
            n_fail++;
            $display("FAIL underflow_b2b: got %b expected %b", {c2, u2}, 3'b00_1);
        end
        cmd(0, 0, 32'h0, 0, 0);
        n_checks++;
        if (u2 !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_clear: got %b expected 0", u2);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        cmd(1, 0, 32'h100, 0, 0);
        cmd(1, 1, 32'h400, 0, 0);
        n_checks++;
        if (st2 !== {1'b1, 2'd1, 32'h400, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pushpop_replace: got %h expected %h", st2, {1'b1, 2'd1, 32'h400, 1'b0, 1'b0});
        end
        cmd(0, 1, 32'h0, 0, 0);
        cmd(1, 1, 32'h500, 0, 0);
        n_checks++;
        if (st2 !== {1'b1, 2'd1, 32'h500, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pushpop_empty: got %h expected %h", st2, {1'b1, 2'd1, 32'h500, 1'b0, 1'b0});
        end
    endtask

    task automatic test_ckpt();
        do_reset();
        cmd(1, 0, 32'h100, 1, 0);
        cmd(1, 0, 32'h200, 0, 0);
        n_checks++;
        if (st2 !== {1'b1, 2'd2, 32'h200, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ckpt_after_push: got %h expected %h", st2, {1'b1, 2'd2, 32'h200, 1'b0, 1'b0});
        end
        cmd(0, 0, 32'h0, 0, 1);
        n_checks++;
        if (st2 !== {1'b1, 2'd1, 32'h100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ckpt_restore: got %h expected %h", st2, {1'b1, 2'd1, 32'h100, 1'b0, 1'b0});
        end
        // Restore wins over a same-cycle push; no write, no pulse.
        cmd(1, 0, 32'h700, 0, 1);
        n_checks++;
        if (st2 !== {1'b1, 2'd1, 32'h100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL restore_push_ignored: got %h expected %h", st2, {1'b1, 2'd1, 32'h100, 1'b0, 1'b0});
        end
        // Restore on empty must not raise underflow even with pop asserted.
        cmd(0, 1, 32'h0, 0, 0);
        cmd(0, 1, 32'h0, 0, 1);
        n_checks++;
        if (st2 !== {1'b1, 2'd1, 32'h100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL restore_pop_ignored: got %h expected %h", st2, {1'b1, 2'd1, 32'h100, 1'b0, 1'b0});
        end
    endtask

    task automatic test_ckpt_edges();
        do_reset();
        cmd(1, 0, 32'h10, 0, 0);
        cmd(0, 0, 32'h0, 0, 1);
        n_checks++;
        if ({v2, c2, o2, u2} !== 5'b0_00_0_0) begin
            n_fail++;
            $display("FAIL restore_no_save: got %b expected %b", {v2, c2, o2, u2}, 5'b0_00_0_0);
        end
        do_reset();
        cmd(1, 0, 32'hA1, 1, 0);
        cmd(1, 0, 32'hB2, 0, 0);
        cmd(0, 0, 32'h0, 1, 1);
        cmd(1, 0, 32'hC3, 0, 0);
        n_checks++;
        if (st2 !== {1'b1, 2'd2, 32'hC3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL save_restore_push: got %h expected %h", st2, {1'b1, 2'd2, 32'hC3, 1'b0, 1'b0});
        end
        cmd(0, 0, 32'h0, 0, 1);
        n_checks++;
        if (st2 !== {1'b1, 2'd1, 32'hA1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL save_restore_coincide: got %h expected %h", st2, {1'b1, 2'd1, 32'hA1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_depth3();
        logic [31:0] exp_top;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cmd(1, 0, 32'(i), 0, 0);
            n_checks++;
            if ({c3, t3, o3} !== {(i >= 3) ? 2'd3 : 2'(i), 32'(i), (i >= 4) ? 1'b1 : 1'b0}) begin
                n_fail++;
                $display("FAIL d3_push%0d: got cnt=%0d top=%h ovf=%b", i, c3, t3, o3);
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_top = 32'(5 - i);
            n_checks++;
            if ({v3, t3} !== {1'b1, exp_top}) begin
                n_fail++;
                $display("FAIL d3_top%0d: got v=%b top=%h expected v=1 top=%h", i, v3, t3, exp_top);
            end
            cmd(0, 1, 32'h0, 0, 0);
        end
        n_checks++;
        if ({v3, c3, o3, u3} !== 5'b0_00_0_0) begin
            n_fail++;
            $display("FAIL d3_empty: got %b expected %b", {v3, c3, o3, u3}, 5'b0_00_0_0);
        end
    endtask

    initial begin
        test_reset();
        test_overflow_underflow();
        test_push_pop();
        test_ckpt();
        test_ckpt_edges();
        test_depth3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
